// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter: word type, arbiter FSM states and
// the requester tag that travels with an access.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    HIT
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  localparam int unsigned MAX_DSTREAK_DEF = 4;
  localparam int unsigned RAM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one single-port RAM with a ready
// handshake. Data wins ties unless instruction fetch has been starved MAX_DSTREAK times.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int unsigned RAM_TIMEOUT = RAM_TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload,
  output logic        memerr,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic        ramready,
  input  logic [31:0] ramload
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam int TW = (RAM_TIMEOUT < 2) ? 1 : $clog2(RAM_TIMEOUT + 1);

  arb_state_t    r_state;
  arb_state_t    w_next;
  arb_src_t      r_src;
  logic          r_wr;
  word_t         r_addr;
  word_t         r_store;
  word_t         r_iload;
  word_t         r_dload;
  logic [SW-1:0] r_dstreak;
  logic [TW-1:0] r_tmo;
  logic          r_memerr;

  logic w_dreq;
  logic w_istarved;
  logic w_grant_d;
  logic w_grant_i;
  logic w_timeout;
  logic w_access;

  assign w_dreq     = dmemREN | dmemWEN;
  assign w_istarved = imemREN && (r_dstreak == SW'(MAX_DSTREAK));
  assign w_access   = (r_state == DACC) || (r_state == IACC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq && !w_istarved) begin
          w_next    = DACC;
          w_grant_d = 1'b1;
        end else if (imemREN) begin
          w_next    = IACC;
          w_grant_i = 1'b1;
        end
      end
      DACC, IACC: begin
        if (ramready) begin
          w_next = HIT;
        end else if (r_tmo == TW'(RAM_TIMEOUT - 1)) begin
          // RAM_TIMEOUT access cycles have elapsed without ramready
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      HIT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Access context latched on the grant edge and held until the next grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_src   <= SRC_I;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else if (w_grant_d) begin
      r_src   <= SRC_D;
      r_wr    <= dmemWEN;
      r_addr  <= dmemaddr;
      r_store <= dmemstore;
    end else if (w_grant_i) begin
      r_src   <= SRC_I;
      r_wr    <= 1'b0;
      r_addr  <= imemaddr;
      r_store <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dstreak <= '0;
    end else if (w_grant_i) begin
      r_dstreak <= '0;
    end else if (w_grant_d && imemREN && (r_dstreak != SW'(MAX_DSTREAK))) begin
      r_dstreak <= r_dstreak + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tmo <= '0;
    end else if (w_grant_d || w_grant_i) begin
      r_tmo <= '0;
    end else if (w_access && !ramready) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // Loads are captured even if the requester abandoned the access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_iload <= '0;
      r_dload <= '0;
    end else if (w_access && ramready && !r_wr) begin
      if (r_src == SRC_I) r_iload <= ramload;
      else                r_dload <= ramload;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_memerr <= 1'b0;
    else     r_memerr <= w_timeout;
  end

  assign ramREN   = w_access && !r_wr;
  assign ramWEN   = w_access && r_wr;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign ihit     = (r_state == HIT) && (r_src == SRC_I) && imemREN;
  assign dhit     = (r_state == HIT) && (r_src == SRC_D) && w_dreq;
  assign imemload = r_iload;
  assign dmemload = r_dload;
  assign memerr   = r_memerr;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: acts as request unit and RAM, predicting grant order,
// strobes, hits and load values from a transaction-level model.
module tb_memory_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore;
  logic        ihit, dhit, memerr, ramREN, ramWEN, ramready;
  logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;

  always #5 CLK = ~CLK;

  memory_arbiter #(.MAX_DSTREAK(MAXS), .RAM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload), .memerr(memerr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramready(ramready), .ramload(ramload)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          pend_i, pend_d, d_wr, d_both;
  logic [31:0] ia, da, ds, m_iload, m_dload, last_addr;
  int          m_streak;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ramval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive();
    imemREN   = pend_i;
    imemaddr  = ia;
    dmemWEN   = pend_d && d_wr;
    dmemREN   = pend_d && (!d_wr || d_both);
    dmemaddr  = da;
    dmemstore = ds;
  endtask

  // lat < 0: RAM never answers; otherwise ramready comes lat cycles after strobes rise.
  task automatic serve(input int lat, input bit abandon, output bit won_d);
    bit wd, wr, tmo;
    logic [31:0] a, v;
    int n;
    wd = pend_d && !(pend_i && m_streak == MAXS);
    won_d = wd;
    if (!wd) m_streak = 0;
    else if (pend_i && m_streak < MAXS) m_streak++;
    wr = wd && d_wr;
    a  = wd ? da : ia;
    v  = wr ? ds : ramval(a);
    for (int k = 0; k < 3 && !(ramREN || ramWEN); k++) begin
      ramready = 1'($urandom);
      ramload  = $urandom;
      step();
    end
    chk("grant_seen", {31'd0, ramREN | ramWEN}, 32'd1);
    if (!(ramREN || ramWEN)) return;
    last_addr = ramaddr;
    tmo = (lat < 0);
    n = tmo ? TMO : lat + 1;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) step();
      chk("ren", {31'd0, ramREN}, {31'd0, !wr});
      chk("wen", {31'd0, ramWEN}, {31'd0, wr});
      chk("addr", ramaddr, a);
      if (wr) chk("store", ramstore, ds);
      chk("pulse_in_acc", {29'd0, ihit, dhit, memerr}, 32'd0);
      if (abandon && wd && c == 1) begin
        pend_d = 0;
        drive();
      end
      if (!tmo && c == n) begin
        ramready = 1'b1;
        ramload  = v;
      end else begin
        ramready = 1'b0;
        ramload  = $urandom;
      end
    end
    step();
    chk("strobe_off", {31'd0, ramREN | ramWEN}, 32'd0);
    if (tmo) begin
      chk("memerr", {31'd0, memerr}, 32'd1);
      chk("hit_on_tmo", {30'd0, ihit, dhit}, 32'd0);
      pend_i = 0;
      pend_d = 0;
    end else begin
      chk("memerr", {31'd0, memerr}, 32'd0);
      chk("ihit", {31'd0, ihit}, {31'd0, !wd && pend_i});
      chk("dhit", {31'd0, dhit}, {31'd0, wd && pend_d});
      if (wr) mem[a] = ds;
      else if (wd) m_dload = v;
      else m_iload = v;
      if (wd) pend_d = 0;
      else pend_i = 0;
    end
    chk("imemload", imemload, m_iload);
    chk("dmemload", dmemload, m_dload);
    drive();
    ramready = 1'($urandom);
    step();
    chk("pulse_end", {29'd0, ihit, dhit, memerr}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    int lat;
    bit ab;
    bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    RST = 1'b1;
    pend_i = 0; pend_d = 0; d_wr = 0; d_both = 0;
    ia = '0; da = '0; ds = '0;
    m_iload = '0; m_dload = '0; m_streak = 0; last_addr = '0;
    drive();
    ramready = 1'b0;
    ramload  = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst_pulses", {29'd0, ihit, dhit, memerr}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_loads", imemload | dmemload | ramstore, 32'd0);
    RST = 1'b0;

    // Reset in the middle of a data write
    pend_d = 1; d_wr = 1; da = 32'h10; ds = 32'h55;
    drive();
    for (int k = 0; k < 3 && !ramWEN; k++) step();
    chk("t1_wen_before", {31'd0, ramWEN}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("t1_wen_async", {31'd0, ramWEN}, 32'd0);
    chk("t1_ren", {31'd0, ramREN}, 32'd0);
    chk("t1_ramaddr", ramaddr, 32'd0);
    chk("t1_ramstore", ramstore, 32'd0);
    chk("t1_pulses", {29'd0, ihit, dhit, memerr}, 32'd0);
    pend_d = 0;
    drive();
    @(posedge CLK);
    #1 RST = 1'b0;
    m_streak = 0; m_iload = '0; m_dload = '0;
    step();
    chk("t1_idle", {31'd0, ramREN | ramWEN}, 32'd0);

    // Instruction fetch with ramready two cycles after grant
    mem[32'h40] = 32'h8C010004;
    pend_i = 1; ia = 32'h40;
    drive();
    serve(1, 0, w);
    chk("t2_iload", imemload, 32'h8C010004);

    // Simultaneous instr and data write: data first
    pend_i = 1; ia = 32'h44;
    pend_d = 1; d_wr = 1; d_both = 0; da = 32'h100; ds = 32'hDEADBEEF;
    drive();
    serve(0, 0, w);
    chk("t3_first", last_addr, 32'h100);
    serve(0, 0, w);
    chk("t3_second", last_addr, 32'h44);

    // Starvation: continuous data reads against a waiting instr fetch
    pend_i = 1; ia = 32'h80;
    for (int i = 0; i < 6; i++) begin
      pend_d = 1; d_wr = 0; d_both = 0; da = 32'h200;
      drive();
      serve(0, 0, w);
      chk("t4_order", last_addr, exp_d[i] ? 32'h200 : 32'h80);
    end
    pend_d = 0;
    drive();

    // Data read abandoned one cycle after grant
    pend_d = 1; d_wr = 0; da = 32'h104;
    drive();
    serve(2, 1, w);
    chk("t5_dload", dmemload, ramval(32'h104));

    // RAM never answers
    pend_d = 1; d_wr = 1; da = 32'h108; ds = 32'h0BAD_F00D;
    drive();
    serve(-1, 0, w);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      if (!pend_i && $urandom_range(0, 2) != 0) begin
        pend_i = 1;
        ia = 32'($urandom_range(0, 63)) << 2;
      end
      if (!pend_d && $urandom_range(0, 2) != 0) begin
        pend_d = 1;
        d_wr   = 1'($urandom);
        d_both = 1'($urandom);
        da     = 32'($urandom_range(0, 63)) << 2;
        ds     = $urandom;
      end
      if (!pend_i && !pend_d) begin
        pend_i = 1;
        ia = 32'($urandom_range(0, 63)) << 2;
      end
      drive();
      lat = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 9) == 0);
      serve(lat, ab, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
